// File: rtl/lcd_msg_pkg.sv
// lcd_msg_pkg: shared FSM states, ASCII constants and default message store for lcd_msg_streamer
package lcd_msg_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_RDY, STROBE, FINISH} state_t;
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] UC_F = 8'h46, UC_P = 8'h50, UC_R = 8'h52, UC_L = 8'h4C;
  localparam logic [7:0] LC_A = 8'h61, LC_I = 8'h69, LC_L = 8'h6C, LC_S = 8'h73;
  localparam logic [7:0] LC_E = 8'h65, LC_D = 8'h64, LC_Y = 8'h79, LC_V = 8'h76;
  localparam int DEF_NUM = 4;
  localparam int DEF_MAX = 5;
  // first character in the most significant byte
  localparam logic [8*DEF_MAX-1:0] DEF_TEXT [DEF_NUM] = '{
    {UC_F, LC_A, LC_I, LC_L, 8'h00},
    {UC_P, LC_A, LC_S, LC_S, 8'h00},
    {UC_R, LC_E, LC_A, LC_D, LC_Y},
    {UC_L, LC_E, LC_V, LC_E, LC_L}
  };
  localparam int DEF_LEN [DEF_NUM] = '{4, 4, 5, 5};
  // stored length, truncated to the configured maximum message length
  function automatic int def_len(input int m, input int max_len);
    if (m < 0 || m >= DEF_NUM) return 0;
    return DEF_LEN[m] < max_len ? DEF_LEN[m] : max_len;
  endfunction
  function automatic logic [7:0] def_byte(input int m, input int i);
    if (m < 0 || m >= DEF_NUM || i < 0 || i >= DEF_LEN[m]) return 8'h00;
    return DEF_TEXT[m][8*(DEF_MAX-1-i) +: 8];
  endfunction
endpackage

// File: rtl/lcd_msg_streamer_rom.sv
// lcd_msg_rom: combinational message store lookup
//   sel  : message index (indices >= NUM_MSG read as empty)
//   idx  : character index within the message
//   data : character byte, 0x00 past the end of the message
//   len  : message length in characters
module lcd_msg_rom
  import lcd_msg_pkg::*;
#(
  parameter int NUM_MSG = 4,
  parameter int MSG_LEN = 16,
  parameter int SW = 2,
  parameter int IW = 4,
  parameter int LW = 5
) (
  input  logic [SW-1:0] sel,
  input  logic [IW-1:0] idx,
  output logic [7:0]    data,
  output logic [LW-1:0] len
);
  assign len = int'(sel) < NUM_MSG ? LW'(def_len(int'(sel), MSG_LEN)) : '0;
  assign data = int'(idx) < int'(len) ? def_byte(int'(sel), int'(idx)) : 8'h00;
endmodule

// File: rtl/lcd_msg_streamer.sv
// lcd_msg_streamer: streams a stored ASCII message to an LCD driver with a strobe/ready handshake
//   clk, reset_not : clock, asynchronous active-low reset
//   start, msg_sel : send request and message index (sampled on acceptance)
//   abort          : cancel the message in progress
//   lcd_ready      : driver can accept the next character
//   lcd_data, lcd_rs, lcd_enable : character byte, data(1)/command(0), strobe
//   busy, done, err: in progress, end-of-message pulse, bad-index pulse
//   LCD_MSG_CLEAR_EN: when defined, a clear-display command precedes every message
module lcd_msg_streamer
  import lcd_msg_pkg::*;
#(
  parameter int NUM_MSG = 4,
  parameter int MSG_LEN = 16,
  parameter int STROBE_CYC = 2,
  localparam int SW = NUM_MSG > 1 ? $clog2(NUM_MSG) : 1,
  localparam int IW = MSG_LEN > 1 ? $clog2(MSG_LEN) : 1,
  localparam int LW = $clog2(MSG_LEN + 1),
  localparam int CW = $clog2(STROBE_CYC + 1)
) (
  input  logic          clk,
  input  logic          reset_not,
  input  logic          start,
  input  logic [SW-1:0] msg_sel,
  input  logic          abort,
  input  logic          lcd_ready,
  output logic [7:0]    lcd_data,
  output logic          lcd_rs,
  output logic          lcd_enable,
  output logic          busy,
  output logic          done,
  output logic          err
);
`ifdef LCD_MSG_CLEAR_EN
  localparam logic CLR = 1'b1;
`else
  localparam logic CLR = 1'b0;
`endif
  state_t st;
  logic [SW-1:0] sel_q;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic pre;
  logic [7:0] rom_data;
  logic [LW-1:0] rom_len;
  logic act, last;
  lcd_msg_rom #(.NUM_MSG(NUM_MSG), .MSG_LEN(MSG_LEN), .SW(SW), .IW(IW), .LW(LW)) u_rom (
    .sel(sel_q), .idx(idx), .data(rom_data), .len(rom_len)
  );
  assign act = st == WAIT_RDY || st == STROBE;
  assign last = LW'(idx) + LW'(1) == rom_len;
  // abort kills the strobe immediately, ahead of the state change
  assign lcd_enable = st == STROBE && !abort;
  assign lcd_rs = !(pre && act);
  assign lcd_data = act ? (pre ? LCD_CMD_CLEAR : rom_data) : 8'h00;
  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      st <= IDLE;
      sel_q <= '0;
      idx <= '0;
      cnt <= '0;
      pre <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      if (abort && st inside {LOAD, WAIT_RDY, STROBE}) begin
        st <= IDLE;
        busy <= 1'b0;
        pre <= 1'b0;
      end else begin
        case (st)
          IDLE: if (start) begin
            sel_q <= msg_sel;
            busy <= 1'b1;
            st <= LOAD;
          end
          LOAD: if (int'(sel_q) >= NUM_MSG) begin
            err <= 1'b1;
            busy <= 1'b0;
            st <= IDLE;
          end else begin
            idx <= '0;
            pre <= CLR;
            // an empty message still sends the clear command when enabled
            if (rom_len == '0 && !CLR) begin
              done <= 1'b1;
              st <= FINISH;
            end else st <= WAIT_RDY;
          end
          WAIT_RDY: if (lcd_ready) begin
            cnt <= '0;
            st <= STROBE;
          end
          STROBE: if (cnt == CW'(STROBE_CYC - 1)) begin
            pre <= 1'b0;
            // the clear command does not consume a character index
            if (pre ? rom_len == '0 : last) begin
              done <= 1'b1;
              st <= FINISH;
            end else begin
              if (!pre) idx <= idx + IW'(1);
              st <= WAIT_RDY;
            end
          end else cnt <= cnt + CW'(1);
          FINISH: begin
            busy <= 1'b0;
            st <= IDLE;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule
